watch_set_ctrl: RTL
===================

Name: watch_set_ctrl

Overview:
Time-set controller for the clock (watch) datapath. It turns debounced button levels into a registered field-select code and one-cycle increment/decrement pulses. Hold-to-repeat, inactivity timeout and a blink phase are handled here. It sits between the button demux and the watch datapath and replaces ad-hoc press handling with a single sequenced FSM.

Parameters:
TICK_DIV, 100000, clk cycles per 1 ms tick (internal divider)
REPEAT_DELAY_MS, 500, hold time before first auto-repeat pulse
REPEAT_PERIOD_MS, 100, interval between subsequent auto-repeat pulses
TIMEOUT_MS, 10000, inactivity time in an edit state before return to IDLE
BLINK_MS, 250, half-period of blink phase

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sw_stopwatch  input  1  1 = stopwatch mode; controller forced to IDLE, buttons ignored
btnL  input  1  debounced level; enter edit / advance field
btnR  input  1  debounced level; exit edit immediately
btnU  input  1  debounced level; increment selected field
btnD  input  1  debounced level; decrement selected field
time_select  output  2  00 none, 01 sec, 10 min, 11 hour
up_down  output  2  01 inc pulse, 10 dec pulse, 00 none; never 11
edit_active  output  1  1 in any edit state
field_blank  output  1  1 during blink-off phase of selected field

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0, all outputs 0, button history 0. Release takes effect at the next clk edge.
- Edge detect: rising edge = level high now and low in the previous registered sample. All outputs are registered. A press first sampled high at edge n gives its response after edge n+1 (one-cycle latency).
- ms tick: internal counter 0..TICK_DIV-1. Tick is a 1-cycle strobe when the counter wraps. It free-runs from reset.
- FSM states: IDLE, SEL_SEC, SEL_MIN, SEL_HOUR. time_select follows the state (00/01/10/11).
  - btnL edge: IDLE->SEL_SEC->SEL_MIN->SEL_HOUR->IDLE.
  - btnR edge: any state->IDLE.
  - btnL and btnR edges in the same cycle: btnR wins.
  - Timeout expiry: edit state->IDLE.
  - sw_stopwatch=1: IDLE is held and every button, repeat and timeout counter is cleared each cycle.
- Inc/dec:
  - Active only in edit states; in IDLE the U/D buttons are ignored and up_down=00.
  - btnU edge gives up_down=01 for exactly 1 cycle; btnD edge gives 10.
  - U and D both high: no pulse, and both hold counters clear.
- Auto-repeat, per button:
  - The hold counter counts ms ticks while the level stays high.
  - On reaching REPEAT_DELAY_MS: one pulse, counter reloads.
  - After that: one pulse every REPEAT_PERIOD_MS while held.
  - Release clears the counter.
  - Counters saturate, never wrap.
- Timeout:
  - The counter counts ms ticks only in edit states.
  - It clears on any button edge, any up_down pulse, and state entry.
  - On reaching TIMEOUT_MS it forces IDLE in the next cycle.
- Blink:
  - In edit states, field_blank toggles every BLINK_MS ticks.
  - It is forced 0, with the phase counter cleared, on state entry and on every up_down pulse, so the edited value is shown immediately.
  - It is 0 in IDLE.
- The datapath owns field wrap-around (sec/min 0..59, hour 0..23); this block never inspects time values.
- State change and a U/D edge in the same cycle: the pulse applies to the old time_select value. Both outputs update on the same edge, so the pulse is qualified by the pre-edge state.

Decomposition:
- Shared package watch_pkg holds:
  - state enum (IDLE, SEL_SEC, SEL_MIN, SEL_HOUR)
  - time_select encodings (TS_NONE, TS_SEC, TS_MIN, TS_HOUR)
  - up_down encodings (UD_NONE, UD_INC, UD_DEC)
- One sub-module, watch_key_repeat: edge detect plus hold/auto-repeat counter, driven by the ms tick and a clear input. It outputs a one-cycle press/repeat strobe and is instantiated twice (U, D).
- Remaining top-level logic: tick divider, FSM, timeout, blink, output registers.

Test Plan:
Bench parameters: TICK_DIV=4, REPEAT_DELAY_MS=5, REPEAT_PERIOD_MS=2, TIMEOUT_MS=20, BLINK_MS=3.
- Reset then btnL pressed 4 times (2 cycles high, 2 low each) -> time_select 01, 10, 11, 00, each one cycle after the press; edit_active high only while time_select≠00.
- In SEL_MIN, btnU pulse (2 cycles) -> exactly one up_down=01 cycle; btnD pulse -> one 10 cycle; in IDLE the same stimulus -> up_down stays 00.
- In SEL_SEC, btnU held 60 clk (15 ms) -> one pulse at press, then pulses at 20 and 28 clk after press plus every 8 clk (total 6); release -> pulses stop.
- In SEL_HOUR with no input for 80 clk (20 ms) -> time_select returns to 00 on the cycle after expiry; a btnU press at 70 clk postpones the return to 20 ms after that press.
- Edit state with btnL and btnR edges in the same cycle -> IDLE; sw_stopwatch raised in SEL_MIN -> IDLE next cycle; btnU/btnD high together -> up_down 00 throughout.
- rst asserted mid-repeat while btnU is held -> outputs 0 asynchronously; after release, btnU still high -> no pulse until a new rising edge and an edit state.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and encodings for the watch time-set controller.
// Field selection states, output encodings and small state helpers.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEL_SEC  = 2'b01,
    SEL_MIN  = 2'b10,
    SEL_HOUR = 2'b11
  } state_t;

  localparam logic [1:0] TS_NONE = 2'b00;
  localparam logic [1:0] TS_SEC  = 2'b01;
  localparam logic [1:0] TS_MIN  = 2'b10;
  localparam logic [1:0] TS_HOUR = 2'b11;

  localparam logic [1:0] UD_NONE = 2'b00;
  localparam logic [1:0] UD_INC  = 2'b01;
  localparam logic [1:0] UD_DEC  = 2'b10;

  function automatic logic [1:0] ts_of(input state_t s);
    case (s)
      SEL_SEC:  return TS_SEC;
      SEL_MIN:  return TS_MIN;
      SEL_HOUR: return TS_HOUR;
      default:  return TS_NONE;
    endcase
  endfunction

  // btnL walks the fields in this order and wraps back to IDLE.
  function automatic state_t next_field(input state_t s);
    case (s)
      IDLE:    return SEL_SEC;
      SEL_SEC: return SEL_MIN;
      SEL_MIN: return SEL_HOUR;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/watch_key_repeat.sv
// Per-button rising-edge detect with hold-to-repeat counter.
// strobe pulses once on the press and then at the auto-repeat cadence while held.
module watch_key_repeat
  import watch_pkg::*;
#(
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic strobe
);

  localparam int MAXV = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
  localparam int HW   = (MAXV > 1) ? $clog2(MAXV + 1) : 1;

  logic          btn_p0;
  logic          btn_p1;
  logic          armed;
  logic          repeating;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_lim;
  logic          count_en;
  logic          rep;

  assign level    = btn_p0;
  assign rise     = btn_p0 & ~btn_p1;
  assign hold_lim = repeating ? HW'(REPEAT_PERIOD_MS - 1) : HW'(REPEAT_DELAY_MS - 1);
  // Only a press that started while unblocked may count towards auto-repeat.
  assign count_en = tick & btn_p0 & ~clr & (armed | rise);
  assign rep      = count_en & armed & (hold_cnt >= hold_lim);
  assign strobe   = ~clr & (rise | rep);

  // p0: sampled level, p1: previous sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0    <= 1'b0;
      btn_p1    <= 1'b0;
      armed     <= 1'b0;
      repeating <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      if (clr || !btn_p0) begin
        armed     <= 1'b0;
        repeating <= 1'b0;
        hold_cnt  <= '0;
      end else begin
        if (rise) armed <= 1'b1;
        if (count_en) begin
          if (hold_cnt >= hold_lim) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: field-select FSM, inc/dec pulses with auto-repeat,
// inactivity timeout and blink phase for the watch datapath.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_DIV         = 100000,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100,
  parameter int TIMEOUT_MS       = 10000,
  parameter int BLINK_MS         = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_stopwatch,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  output logic [1:0] time_select,
  output logic [1:0] up_down,
  output logic       edit_active,
  output logic       field_blank
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam int BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            l_p0, l_p1, r_p0, r_p1;
  logic            l_rise, r_rise;
  logic            u_lvl, u_rise, u_str;
  logic            d_lvl, d_rise, d_str;
  logic            key_clr;
  logic            any_rise;
  state_t          state, state_next;
  logic [1:0]      ud_next;
  logic [TO_W-1:0] to_cnt;
  logic [BL_W-1:0] bl_cnt;

  assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
  assign l_rise   = l_p0 & ~l_p1;
  assign r_rise   = r_p0 & ~r_p1;
  assign key_clr  = sw_stopwatch | (state == IDLE) | (u_lvl & d_lvl);
  assign any_rise = l_rise | r_rise | u_rise | d_rise;

  watch_key_repeat #(
    .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
    .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS)
  ) u_key_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btnU),
    .tick  (tick),
    .clr   (key_clr),
    .level (u_lvl),
    .rise  (u_rise),
    .strobe(u_str)
  );

  watch_key_repeat #(
    .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
    .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS)
  ) u_key_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btnD),
    .tick  (tick),
    .clr   (key_clr),
    .level (d_lvl),
    .rise  (d_rise),
    .strobe(d_str)
  );

  // btnR outranks btnL; timeout and stopwatch mode both force IDLE.
  always_comb begin
    state_next = state;
    if (sw_stopwatch || r_rise || (to_cnt == TO_W'(TIMEOUT_MS))) state_next = IDLE;
    else if (l_rise) state_next = next_field(state);
  end

  // Qualified by the pre-edge state so a pulse lands on the field it was aimed at.
  always_comb begin
    ud_next = UD_NONE;
    if (state != IDLE && !sw_stopwatch) begin
      if (u_str && !d_str) ud_next = UD_INC;
      else if (d_str && !u_str) ud_next = UD_DEC;
    end
  end

  // p0: ms tick divider and L/R sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      l_p0     <= 1'b0;
      l_p1     <= 1'b0;
      r_p0     <= 1'b0;
      r_p1     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      l_p0     <= btnL;
      l_p1     <= l_p0;
      r_p0     <= btnR;
      r_p1     <= r_p0;
    end
  end

  // p1: inactivity timeout and blink phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      bl_cnt      <= '0;
      field_blank <= 1'b0;
    end else begin
      if (state == IDLE || state_next != state || sw_stopwatch || any_rise || ud_next != UD_NONE)
        to_cnt <= '0;
      else if (tick && to_cnt != TO_W'(TIMEOUT_MS))
        to_cnt <= to_cnt + 1'b1;

      if (state == IDLE || state_next != state || ud_next != UD_NONE) begin
        bl_cnt      <= '0;
        field_blank <= 1'b0;
      end else if (tick) begin
        if (bl_cnt == BL_W'(BLINK_MS - 1)) begin
          bl_cnt      <= '0;
          field_blank <= ~field_blank;
        end else begin
          bl_cnt <= bl_cnt + 1'b1;
        end
      end
    end
  end

  // p2: state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      time_select <= TS_NONE;
      edit_active <= 1'b0;
      up_down     <= UD_NONE;
    end else begin
      state       <= state_next;
      time_select <= ts_of(state_next);
      edit_active <= (state_next != IDLE);
      up_down     <= ud_next;
    end
  end

endmodule
